// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier blocks.
//   arb_state_t    : arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   W_DEFAULT      : default operand width (product is 2*W_DEFAULT)
//   mult_control_t : multiplier handshake bundle (start strobe + done history)
// -----------------------------------------------------------------------------
package booth_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // valid: start strobe towards the multiplier
  // done : previous-cycle copy of the multiplier done level, used for edge detect
  typedef struct packed {
    logic valid;
    logic done;
  } mult_control_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Search starts at (rr_ptr+1) mod NREQ and
// wraps, so the requester at rr_ptr itself has the lowest priority.
//   req       in  NREQ  request vector
//   rr_ptr    in  IDW   index of the most recent grant
//   grant     out NREQ  one-hot grant (all zero when no request)
//   grant_idx out IDW   index of the granted requester
//   any_valid out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  assign any_valid = |req;

  // Walk the candidates from lowest to highest priority; the last hit wins,
  // which avoids a separate "found" flag.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// -----------------------------------------------------------------------------
// booth_mult_arbiter
// Shares one signed WxW multiplier between NREQ requesters. One operation is in
// flight at a time; responses come back on a single channel tagged with the id.
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (ready only in IDLE)
//   req_a/req_b         packed operands, slice i belongs to requester i
//   rsp_*               response channel (id, product, timeout error flag)
//   mul_valid/mul_a/b   start strobe and held operands to the multiplier
//   mul_done/mul_result multiplier completion level and product
// -----------------------------------------------------------------------------
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int W           = W_DEFAULT,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              mul_valid,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_result
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  arb_state_t     state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           any_valid;
  logic           issue_second;
  logic [TW-1:0]  timer;
  mult_control_t  mul_ctl;
  logic           completion;
  logic           timed_out;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Ready is combinational so the grant is visible in the same IDLE cycle.
  assign req_ready  = (state == IDLE && !rst) ? grant : '0;
  assign mul_valid  = mul_ctl.valid;
  // Only a fresh rising edge counts; a level left high by the last op is stale.
  assign completion = mul_done && !mul_ctl.done;
  assign timed_out  = (timer == TW'(TIMEOUT_CYC - 1));

  // Main FSM: grant, hold operands, strobe the multiplier for two cycles,
  // wait for completion or timeout, then hold the response until accepted.
  // done history is tracked every cycle so a level already high on WAIT entry
  // is seen as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_q         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      mul_ctl      <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      timer        <= '0;
      issue_second <= 1'b0;
    end else begin
      mul_ctl.done <= mul_done;
      case (state)
        IDLE: begin
          if (any_valid) begin
            mul_a         <= req_a[int'(grant_idx)*W +: W];
            mul_b         <= req_b[int'(grant_idx)*W +: W];
            id_q          <= grant_idx;
            rr_ptr        <= grant_idx;
            mul_ctl.valid <= 1'b1;
            issue_second  <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          if (issue_second) begin
            mul_ctl.valid <= 1'b0;
            state         <= WAIT;
          end else begin
            issue_second <= 1'b1;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (completion) begin
            rsp_data  <= mul_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            state     <= RESP;
          end else if (timed_out) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_arbiter
// Self-checking bench for booth_mult_arbiter with a behavioural multiplier and
// a round-robin/product reference model.
// -----------------------------------------------------------------------------
module tb_booth_mult_arbiter;

  localparam int NREQ        = 4;
  localparam int W           = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int IDW         = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              rsp_err;
  logic              mul_valid;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done;
  logic [2*W-1:0]    mul_result;

  logic [7:0] op_a [NREQ];
  logic [7:0] op_b [NREQ];
  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  // Multiplier stand-in: automatic behavioural model or direct manual control.
  bit          auto_mode = 1'b1;
  logic        man_done  = 1'b0;
  logic [15:0] man_res   = '0;
  bit          m_busy    = 1'b0;
  bit          m_done    = 1'b0;
  int          m_cnt     = 0;
  int          mul_lat   = 3;
  logic [15:0] m_res     = '0;
  logic [15:0] m_pend    = '0;
  assign mul_done   = auto_mode ? m_done : man_done;
  assign mul_result = auto_mode ? m_res : man_res;

  int checks = 0;
  int errors = 0;
  int tb_ptr = 0;

  booth_mult_arbiter #(
    .NREQ        (NREQ),
    .W           (W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .IDW         (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Round-robin rule: first valid requester after the last grant, wrapping.
  function automatic int rr_next(input logic [3:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_res = '0; m_pend = '0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
      end
    end else if (mul_valid) begin
      m_busy = 1'b1; m_done = 1'b0; m_cnt = mul_lat;
      m_pend = ref_mul(mul_a, mul_b);
    end
  end

  task automatic wait_grant(input int budget, output logic [3:0] gv);
    gv = '0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (req_ready != '0) begin
        gv = req_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full operation with rsp_ready high; returns observations, no checks.
  // Called at a negedge; returns at the negedge of the following IDLE cycle.
  task automatic transact(output logic [3:0] gv, output bit got, output logic [1:0] id,
                          output logic [15:0] data, output logic err, output int mv,
                          output bit hold_bad, output bit leak,
                          output logic [7:0] a0, output logic [7:0] b0);
    got = 0; id = '0; data = '0; err = 0; mv = 0; hold_bad = 0; leak = 0;
    a0 = '0; b0 = '0;
    wait_grant(20, gv);
    if (gv == '0) return;
    @(negedge clk);
    a0 = mul_a; b0 = mul_b;
    for (int c = 0; c < 200 && !got; c++) begin
      if (mul_valid) mv++;
      if (req_ready != '0) leak = 1;
      if (mul_a !== a0 || mul_b !== b0) hold_bad = 1;
      if (rsp_valid) begin
        got = 1; id = rsp_id; data = rsp_data; err = rsp_err;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got valid=%b err=%b expected 0/0", rsp_valid, rsp_err); end
    checks++; if (rsp_id !== 2'd0 || rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_fields: got id=%0d data=%h expected 0/0000", rsp_id, rsp_data); end
    checks++; if (mul_valid !== 1'b0 || mul_a !== 8'h0 || mul_b !== 8'h0) begin errors++; $display("FAIL reset_mul: got v=%b a=%h b=%h expected 0/00/00", mul_valid, mul_a, mul_b); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tb_ptr = 0;
  endtask

  task automatic test_single();
    logic [3:0] gv; bit got, hb, lk; logic [1:0] id; logic [15:0] d; logic e; int mv;
    logic [7:0] a0, b0;
    op_a[0] = 8'd3; op_b[0] = 8'hFE; mul_lat = 4;
    req_valid = 4'b0001;
    transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
    req_valid = '0;
    checks++; if (gv !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", gv); end
    checks++; if (!got || id !== 2'd0 || e !== 1'b0) begin errors++; $display("FAIL single_rsp: got got=%0d id=%0d err=%b expected 1/0/0", got, id, e); end
    checks++; if (d !== ref_mul(8'd3, 8'hFE)) begin errors++; $display("FAIL single_data: got %h expected %h", d, ref_mul(8'd3, 8'hFE)); end
    checks++; if (a0 !== 8'd3 || b0 !== 8'hFE || hb) begin errors++; $display("FAIL single_operands: got a=%h b=%h changed=%0d expected 03/fe/0", a0, b0, hb); end
    checks++; if (mv !== 2) begin errors++; $display("FAIL single_mul_valid_len: got %0d expected 2", mv); end
    tb_ptr = 0;
  endtask

  task automatic test_all_valid();
    logic [3:0] gv; bit got, hb, lk; logic [1:0] id; logic [15:0] d; logic e; int mv, ex;
    logic [7:0] a0, b0;
    op_a[0] = 8'h00; op_b[0] = 8'hFF;
    op_a[1] = 8'd5;  op_b[1] = 8'd7;
    op_a[2] = 8'hF8; op_b[2] = 8'hF8;
    op_a[3] = 8'h7F; op_b[3] = 8'h80;
    req_valid = 4'hF; mul_lat = 3;
    for (int n = 0; n < 5; n++) begin
      ex = rr_next(req_valid, tb_ptr);
      transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
      checks++; if (gv !== (4'b0001 << ex)) begin errors++; $display("FAIL all_grant%0d: got %b expected id %0d", n, gv, ex); end
      checks++; if (!got || id !== 2'(ex)) begin errors++; $display("FAIL all_id%0d: got %0d (rsp=%0d) expected %0d", n, id, got, ex); end
      checks++; if (d !== ref_mul(op_a[ex], op_b[ex]) || e !== 1'b0) begin errors++; $display("FAIL all_data%0d: got %h err=%b expected %h", n, d, e, ref_mul(op_a[ex], op_b[ex])); end
      checks++; if (lk) begin errors++; $display("FAIL all_ready_leak%0d: got ready outside IDLE expected none", n); end
      tb_ptr = ex;
    end
    req_valid = '0;
  endtask

  task automatic test_pointer();
    logic [3:0] gv; bit got, hb, lk; logic [1:0] id; logic [15:0] d; logic e; int mv, ex;
    logic [7:0] a0, b0;
    op_a[2] = 8'd9; op_b[2] = 8'hFD;
    req_valid = 4'b0100;
    ex = rr_next(req_valid, tb_ptr);
    transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
    checks++; if (gv !== 4'b0100 || id !== 2'd2) begin errors++; $display("FAIL ptr_setup: got %b id=%0d expected 0100/2", gv, id); end
    tb_ptr = ex;
    req_valid = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      ex = rr_next(req_valid, tb_ptr);
      transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
      checks++; if (gv !== (4'b0001 << ex) || !got || id !== 2'(ex)) begin errors++; $display("FAIL ptr_grant%0d: got %b id=%0d expected id %0d", n, gv, id, ex); end
      tb_ptr = ex;
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    logic [3:0] gv; bit got, unstable, leak; logic [1:0] id0; logic [15:0] d0; logic e0;
    int ex;
    op_a[1] = 8'($urandom); op_b[1] = 8'($urandom); mul_lat = 4;
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    ex = rr_next(req_valid, tb_ptr);
    wait_grant(20, gv);
    checks++; if (gv !== (4'b0001 << ex)) begin errors++; $display("FAIL bp_grant: got %b expected id %0d", gv, ex); end
    @(negedge clk);
    req_valid = 4'b1000;
    tb_ptr = ex;
    wait_rsp(100, got);
    id0 = rsp_id; d0 = rsp_data; e0 = rsp_err;
    checks++; if (!got || id0 !== 2'(ex) || d0 !== ref_mul(op_a[ex], op_b[ex]) || e0 !== 1'b0) begin errors++; $display("FAIL bp_rsp: got rsp=%0d id=%0d data=%h err=%b expected id %0d data %h", got, id0, d0, e0, ex, ref_mul(op_a[ex], op_b[ex])); end
    unstable = 0; leak = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_id !== id0 || rsp_data !== d0 || rsp_err !== e0) unstable = 1;
      if (req_ready != '0) leak = 1;
    end
    checks++; if (unstable) begin errors++; $display("FAIL bp_stable: got response change while stalled expected stable"); end
    checks++; if (leak) begin errors++; $display("FAIL bp_ready: got req_ready during RESP expected 0"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got rsp_valid=%b expected 0", rsp_valid); end
    ex = rr_next(req_valid, tb_ptr);
    #1;
    checks++; if (req_ready !== (4'b0001 << ex)) begin errors++; $display("FAIL bp_next_grant: got %b expected id %0d", req_ready, ex); end
    @(negedge clk);
    req_valid = '0;
    tb_ptr = ex;
    wait_rsp(100, got);
    checks++; if (!got || rsp_id !== 2'(ex)) begin errors++; $display("FAIL bp_second_rsp: got rsp=%0d id=%0d expected id %0d", got, rsp_id, ex); end
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    logic [3:0] gv; bit got, early; int ex;
    auto_mode = 0; man_done = 1'b1; man_res = 16'h1234;
    op_a[0] = 8'd11; op_b[0] = 8'd13;
    req_valid = 4'b0001;
    ex = rr_next(req_valid, tb_ptr);
    wait_grant(20, gv);
    checks++; if (gv !== (4'b0001 << ex)) begin errors++; $display("FAIL stale_grant: got %b expected id %0d", gv, ex); end
    tb_ptr = ex;
    @(negedge clk);
    req_valid = '0;
    early = 0;
    repeat (8) begin
      if (rsp_valid) early = 1;
      @(negedge clk);
    end
    checks++; if (early) begin errors++; $display("FAIL stale_ignored: got response on stale done expected none"); end
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_res = 16'hBEEF; man_done = 1'b1;
    wait_rsp(10, got);
    checks++; if (!got || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || rsp_id !== 2'(ex)) begin errors++; $display("FAIL stale_complete: got rsp=%0d data=%h err=%b id=%0d expected beef/0/%0d", got, rsp_data, rsp_err, rsp_id, ex); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0] gv; bit got; int wc, ex;
    auto_mode = 0; man_done = 1'b0;
    req_valid = 4'b0100;
    ex = rr_next(req_valid, tb_ptr);
    wait_grant(20, gv);
    tb_ptr = ex;
    @(negedge clk);
    req_valid = '0;
    got = 0; wc = 0;
    for (int c = 0; c < 200; c++) begin
      if (rsp_valid) begin got = 1; break; end
      if (!mul_valid) wc++;
      @(negedge clk);
    end
    checks++; if (!got || wc !== TIMEOUT_CYC) begin errors++; $display("FAIL timeout_len: got rsp=%0d wait_cycles=%0d expected %0d", got, wc, TIMEOUT_CYC); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'h0 || rsp_id !== 2'(ex)) begin errors++; $display("FAIL timeout_rsp: got err=%b data=%h id=%0d expected 1/0000/%0d", rsp_err, rsp_data, rsp_id, ex); end
    @(negedge clk);
    auto_mode = 1;
  endtask

  task automatic test_random();
    logic [3:0] gv, mask; bit got, hb, lk; logic [1:0] id; logic [15:0] d; logic e; int mv, ex;
    logic [7:0] a0, b0;
    for (int n = 0; n < 12; n++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = 8'($urandom); op_b[i] = 8'($urandom);
      end
      mul_lat = $urandom_range(2, 10);
      req_valid = mask;
      ex = rr_next(mask, tb_ptr);
      transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
      checks++; if (gv !== (4'b0001 << ex) || !got || id !== 2'(ex)) begin errors++; $display("FAIL rnd_grant%0d: got %b id=%0d expected id %0d", n, gv, id, ex); end
      checks++; if (d !== ref_mul(op_a[ex], op_b[ex]) || e !== 1'b0) begin errors++; $display("FAIL rnd_data%0d: got %h err=%b expected %h", n, d, e, ref_mul(op_a[ex], op_b[ex])); end
      checks++; if (a0 !== op_a[ex] || b0 !== op_b[ex] || hb || mv !== 2 || lk) begin errors++; $display("FAIL rnd_issue%0d: got a=%h b=%h hold_bad=%0d mv=%0d leak=%0d expected %h %h 0 2 0", n, a0, b0, hb, mv, lk, op_a[ex], op_b[ex]); end
      tb_ptr = ex;
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] gv; bit got, hb, lk, seen; logic [1:0] id; logic [15:0] d; logic e; int mv;
    logic [7:0] a0, b0;
    auto_mode = 0; man_done = 1'b0;
    op_a[1] = 8'h5A; op_b[1] = 8'hA5;
    req_valid = 4'b0010;
    wait_grant(20, gv);
    @(negedge clk);
    req_valid = '0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mul_a !== 8'h0 || mul_b !== 8'h0 || mul_valid !== 1'b0) begin errors++; $display("FAIL rstw_mul: got a=%h b=%h v=%b expected 0", mul_a, mul_b, mul_valid); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 || req_ready !== 4'h0) begin errors++; $display("FAIL rstw_rsp: got v=%b id=%0d d=%h e=%b rdy=%h expected all 0", rsp_valid, rsp_id, rsp_data, rsp_err, req_ready); end
    rst = 1'b0;
    seen = 0;
    repeat (TIMEOUT_CYC + 16) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstw_silent: got response for aborted op expected none"); end
    auto_mode = 1; tb_ptr = 0; mul_lat = 3;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 8'(i + 2); op_b[i] = 8'hF0;
    end
    req_valid = 4'hF;
    transact(gv, got, id, d, e, mv, hb, lk, a0, b0);
    req_valid = '0;
    checks++; if (gv !== (4'b0001 << rr_next(4'hF, 0)) || !got || d !== ref_mul(op_a[1], op_b[1])) begin errors++; $display("FAIL rstw_ptr: got %b data=%h expected id 1 data %h", gv, d, ref_mul(op_a[1], op_b[1])); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0;
    end
    test_reset();
    test_single();
    test_all_valid();
    test_pointer();
    test_back_pressure();
    test_stale_done();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
